// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared VGA timing constants for 640x480@60 Hz, default 4:4:4 colours, the
// RGB typedef used by the compositor, and a window-compare helper used to
// decode sync pulses from the raster counters.
// -----------------------------------------------------------------------------
package vga_pkg;

    // Horizontal timing (pixels)
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    // Vertical timing (lines)
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Default colours (4:4:4)
    localparam logic [11:0] FG_COLOR_DEF = 12'h555;
    localparam logic [11:0] BG_COLOR_DEF = 12'hFFF;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // True when start <= pos < stop
    function automatic logic in_window(
        input logic [9:0] pos,
        input logic [9:0] start,
        input logic [9:0] stop
    );
        return (pos >= start) && (pos < stop);
    endfunction

endpackage

// File: rtl/sync_delay.sv
// -----------------------------------------------------------------------------
// sync_delay
// Parameterised-depth shift register with enable and asynchronous active-low
// clear. Used to align video_on/hsync/vsync with render-block pixel latency.
//   clk     : pixel clock
//   reset_n : asynchronous active-low clear, every stage loads RST_VAL
//   en      : shift enable; stages hold when low
//   d       : input word
//   q       : word delayed by DEPTH enabled cycles (combinational pass if 0)
// -----------------------------------------------------------------------------
module sync_delay #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(0)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            // Next-state of the shift chain: shift on enable, otherwise hold
            always_comb begin
                stage_d = stage_q;
                if (en) begin
                    stage_d[0] = d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                end else begin
                    stage_d = stage_q;
                end
            end

            // Stage registers with asynchronous clear
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RST_VAL;
                    end
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign q = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_sync.sv
// -----------------------------------------------------------------------------
// vga_sync
// Raster timing generator and pixel compositor for the VGA output.
//   clk          : pixel clock (25.175 MHz for 640x480@60)
//   reset_n      : asynchronous active-low reset
//   en           : pixel enable; all state advances only when high
//   layer_pixel  : registered 1-bit pixels from render blocks (PIX_LAT behind)
//   invert       : night-mode request, sampled once per frame at frame_tick
//   haddress     : current column, 0..H_TOTAL-1
//   vaddress     : current line, 0..V_TOTAL-1
//   frame_tick   : one-en-cycle pulse while the scan sits at (0, V_ACTIVE)
//   hsync, vsync : active-low sync, aligned with RGB
//   red/green/blue : 4:4:4 pixel colour, black in blanking
// Outputs for the address presented in en-cycle n appear after en-edge
// n+PIX_LAT+1.
// -----------------------------------------------------------------------------
module vga_sync
    import vga_pkg::*;
#(
    parameter int          H_ACTIVE = H_ACTIVE_DEF,
    parameter int          H_FP     = H_FP_DEF,
    parameter int          H_SYNC   = H_SYNC_DEF,
    parameter int          H_BP     = H_BP_DEF,
    parameter int          V_ACTIVE = V_ACTIVE_DEF,
    parameter int          V_FP     = V_FP_DEF,
    parameter int          V_SYNC   = V_SYNC_DEF,
    parameter int          V_BP     = V_BP_DEF,
    parameter int          N_LAYERS = 4,
    parameter int          PIX_LAT  = 1,
    parameter logic [11:0] FG_COLOR = FG_COLOR_DEF,
    parameter logic [11:0] BG_COLOR = BG_COLOR_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic [N_LAYERS-1:0] layer_pixel,
    input  logic                invert,
    output logic [9:0]          haddress,
    output logic [9:0]          vaddress,
    output logic                frame_tick,
    output logic                hsync,
    output logic                vsync,
    output logic [3:0]          red,
    output logic [3:0]          green,
    output logic [3:0]          blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Delay-line word: {video_on, hsync_n, vsync_n}; cleared to blank, sync high
    localparam logic [2:0] DLY_RST = 3'b011;

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       tick_q, tick_d;
    logic       night_q, night_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    rgb_t       rgb_q, rgb_d;

    logic [2:0] raw_s;
    logic [2:0] dly_s;
    logic       dly_video_s;
    logic       dly_hs_s;
    logic       dly_vs_s;
    logic       pix_on_s;

    // Raw timing decode straight from the counters
    always_comb begin
        raw_s    = DLY_RST;
        raw_s[2] = (h_q < H_ACT) && (v_q < V_ACT);
        raw_s[1] = ~in_window(h_q, HS_START, HS_END);
        raw_s[0] = ~in_window(v_q, VS_START, VS_END);
    end

    sync_delay #(
        .WIDTH   (3),
        .DEPTH   (PIX_LAT),
        .RST_VAL (DLY_RST)
    ) u_sync_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .d       (raw_s),
        .q       (dly_s)
    );

    assign dly_video_s = dly_s[2];
    assign dly_hs_s    = dly_s[1];
    assign dly_vs_s    = dly_s[0];
    // Night mode swaps which of FG/BG a lit pixel selects
    assign pix_on_s    = (|layer_pixel) ^ night_q;

    // Next-state for counters, tick, night mode and the output stage
    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        tick_d  = tick_q;
        night_d = night_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        rgb_d   = rgb_q;
        if (en) begin
            if (h_q == H_LAST) begin
                h_d = 10'd0;
                if (v_q == V_LAST) begin
                    v_d = 10'd0;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
            // High exactly while the counters read (0, V_ACTIVE)
            tick_d = (h_q == H_LAST) && (v_q == V_ACT_LAST);
            // Night mode only changes on the tick cycle so a frame never tears
            if (tick_q) begin
                night_d = invert;
            end else begin
                night_d = night_q;
            end
            hs_d = dly_hs_s;
            vs_d = dly_vs_s;
            if (!dly_video_s) begin
                rgb_d = rgb_t'(12'h000);
            end else if (pix_on_s) begin
                rgb_d = rgb_t'(FG_COLOR);
            end else begin
                rgb_d = rgb_t'(BG_COLOR);
            end
        end else begin
            h_d = h_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q     <= 10'd0;
            v_q     <= 10'd0;
            tick_q  <= 1'b0;
            night_q <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            rgb_q   <= rgb_t'(12'h000);
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            tick_q  <= tick_d;
            night_q <= night_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            rgb_q   <= rgb_d;
        end
    end

    assign haddress   = h_q;
    assign vaddress   = v_q;
    assign frame_tick = tick_q;
    assign hsync      = hs_q;
    assign vsync      = vs_q;
    assign red        = rgb_q.r;
    assign green      = rgb_q.g;
    assign blue       = rgb_q.b;

endmodule

// File: tb/tb_vga_sync.sv
// -----------------------------------------------------------------------------
// tb_vga_sync
// Self-checking bench for vga_sync using a shrunken raster (25x15) so whole
// frames fit in a short run. The reference model tracks only the number of
// enabled cycles since reset and derives address, sync, colour and tick from
// it arithmetically.
// -----------------------------------------------------------------------------
module tb_vga_sync;

    localparam int HA = 16, HFP = 2, HSW = 4, HBP = 3;
    localparam int VA = 8,  VFP = 2, VSW = 2, VBP = 3;
    localparam int HT = HA + HFP + HSW + HBP;   // 25
    localparam int VT = VA + VFP + VSW + VBP;   // 15
    localparam int FT = HT * VT;                // 375
    localparam int TICK_POS = VA * HT;          // 200
    localparam logic [11:0] FG = 12'h555;
    localparam logic [11:0] BG = 12'hFFF;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] layer_pixel = 4'd0;
    logic       invert = 1'b0;
    logic [9:0] haddress, vaddress;
    logic       frame_tick, hsync, vsync;
    logic [3:0] red, green, blue;

    vga_sync #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .N_LAYERS(4), .PIX_LAT(1), .FG_COLOR(FG), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .layer_pixel(layer_pixel),
        .invert(invert), .haddress(haddress), .vaddress(vaddress),
        .frame_tick(frame_tick), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cnt = 0;          // enabled cycles since reset release
    logic night_m = 1'b0;
    logic exp_hs = 1'b1;
    logic exp_vs = 1'b1;
    logic [11:0] exp_rgb = 12'h000;

    typedef struct {
        int k; int h; int v; logic hs; logic vs; logic tk; logic [11:0] rgb;
    } vec_t;
    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cnt=%0d)", name, act, exp, cnt);
        end
    endtask

    task automatic model_reset();
        cnt = 0; night_m = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 12'h000;
    endtask

    task automatic check_model();
        check("haddress", 32'(haddress), 32'(cnt % HT));
        check("vaddress", 32'(vaddress), 32'((cnt / HT) % VT));
        check("frame_tick", 32'(frame_tick), 32'((cnt % FT) == TICK_POS));
        check("hsync", 32'(hsync), 32'(exp_hs));
        check("vsync", 32'(vsync), 32'(exp_vs));
        check("rgb", 32'({red, green, blue}), 32'(exp_rgb));
    endtask

    // One clock: drive inputs, advance model on enabled edges, compare after edge
    task automatic step(input logic en_v, input logic inv_v, input logic [3:0] lay_v);
        int a, ah, av;
        en = en_v; invert = inv_v; layer_pixel = lay_v;
        @(posedge clk);
        if (en_v) begin
            if (cnt >= 1) begin
                a  = cnt - 1;   // address whose outputs land after this edge
                ah = a % HT;
                av = (a / HT) % VT;
                exp_hs = !(ah >= HA + HFP && ah < HA + HFP + HSW);
                exp_vs = !(av >= VA + VFP && av < VA + VFP + VSW);
                if (ah < HA && av < VA) exp_rgb = ((lay_v != 4'd0) != night_m) ? FG : BG;
                else exp_rgb = 12'h000;
            end
            if ((cnt % FT) == TICK_POS) night_m = inv_v;
            cnt++;
        end
        #1;
        check_model();
    endtask

    // Render block that lights only address (10,5), one cycle behind the scan
    function automatic logic [3:0] render_pix();
        int a;
        if (cnt < 1) return 4'd0;
        a = cnt - 1;
        return ((a % HT) == 10 && ((a / HT) % VT) == 5) ? 4'b0001 : 4'b0000;
    endfunction

    initial begin
        int hs_low, vs_low, ticks, fg_seen, tick_run;
        logic inv_r;

        tbl[0]  = '{0,   0,  0,  1'b1, 1'b1, 1'b0, 12'h000};
        tbl[1]  = '{2,   2,  0,  1'b1, 1'b1, 1'b0, 12'hFFF};
        tbl[2]  = '{17,  17, 0,  1'b1, 1'b1, 1'b0, 12'hFFF};
        tbl[3]  = '{18,  18, 0,  1'b1, 1'b1, 1'b0, 12'h000};
        tbl[4]  = '{20,  20, 0,  1'b0, 1'b1, 1'b0, 12'h000};
        tbl[5]  = '{23,  23, 0,  1'b0, 1'b1, 1'b0, 12'h000};
        tbl[6]  = '{24,  24, 0,  1'b1, 1'b1, 1'b0, 12'h000};
        tbl[7]  = '{25,  0,  1,  1'b1, 1'b1, 1'b0, 12'h000};
        tbl[8]  = '{200, 0,  8,  1'b1, 1'b1, 1'b1, 12'h000};
        tbl[9]  = '{201, 1,  8,  1'b1, 1'b1, 1'b0, 12'h000};
        tbl[10] = '{252, 2,  10, 1'b1, 1'b0, 1'b0, 12'h000};
        tbl[11] = '{300, 0,  12, 1'b1, 1'b0, 1'b0, 12'h000};
        tbl[12] = '{302, 2,  12, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[13] = '{375, 0,  0,  1'b1, 1'b1, 1'b0, 12'h000};
        tbl[14] = '{377, 2,  0,  1'b1, 1'b1, 1'b0, 12'hFFF};

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        reset_n = 1'b1;

        // Directed table over the first frame, plus per-frame sync statistics
        hs_low = 0; vs_low = 0; ticks = 0;
        for (int i = 0; i < 15; i++) begin
            while (cnt < tbl[i].k) begin
                step(1'b1, 1'b0, 4'd0);
                if (cnt >= 2 && cnt <= 376) begin
                    if (!hsync) hs_low++;
                    if (!vsync) vs_low++;
                end
                if (cnt >= 1 && cnt <= 375 && frame_tick) ticks++;
            end
            check("tbl_h",   32'(haddress),   32'(tbl[i].h));
            check("tbl_v",   32'(vaddress),   32'(tbl[i].v));
            check("tbl_hs",  32'(hsync),      32'(tbl[i].hs));
            check("tbl_vs",  32'(vsync),      32'(tbl[i].vs));
            check("tbl_tick", 32'(frame_tick), 32'(tbl[i].tk));
            check("tbl_rgb", 32'({red, green, blue}), 32'(tbl[i].rgb));
        end
        check("hsync_low_cycles", 32'(hs_low), 32'(VT * HSW));
        check("vsync_low_cycles", 32'(vs_low), 32'(VSW * HT));
        check("ticks_per_frame",  32'(ticks),  32'd1);

        // Single lit render pixel at (10,5): exactly one FG output per frame
        fg_seen = 0;
        repeat (FT) begin
            step(1'b1, 1'b0, render_pix());
            if ({red, green, blue} == FG) fg_seen++;
        end
        check("single_fg_pixel", 32'(fg_seen), 32'd1);

        // Night mode: invert raised mid-frame, takes effect only at the tick
        while ((cnt % FT) != 100) step(1'b1, 1'b0, 4'd0);
        while ((cnt % FT) != TICK_POS + 50) step(1'b1, 1'b1, 4'd0);
        while ((cnt % FT) != 2) step(1'b1, 1'b0, 4'd0);
        check("night_bg", 32'({red, green, blue}), 32'(FG));
        while ((cnt % FT) != TICK_POS + 3) step(1'b1, 1'b0, render_pix());

        // Alternating enable across a tick: tick spans at most 2 clocks
        tick_run = 0;
        for (int i = 0; i < 2 * FT + 10; i++) begin
            step(1'(i % 2), 1'b0, 4'(i % 3));
            if (frame_tick) tick_run++;
        end
        check("tick_clocks_half_rate", 32'(tick_run), 32'd2);

        // Asynchronous reset mid-frame at (12,5)
        while ((cnt % FT) != 5 * HT + 12) step(1'b1, 1'b1, 4'd0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_h", 32'(haddress), 32'd0);
        check("rst_v", 32'(vaddress), 32'd0);
        check("rst_sync", 32'({hsync, vsync}), 32'd3);
        check("rst_rgb", 32'({red, green, blue}), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_model();
        end
        reset_n = 1'b1;

        // Randomised enable, layers and occasional invert changes
        inv_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) inv_r = ~inv_r;
            step(1'($urandom_range(0, 3) != 0), inv_r, 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sync.md
# vga_sync

Display timing generator and pixel compositor for the 640x480@60 Hz VGA output. Produces the `haddress`/`vaddress` raster scan that all sprite/score/ground render blocks consume, collects their registered 1-bit pixel outputs, and drives `hsync`, `vsync` and 12-bit RGB to the connector. Also emits a once-per-frame tick for game logic and applies a frame-synchronous colour invert (night mode).

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch and sync widths (line total 800)
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch and sync lines (frame total 525)
- `N_LAYERS`, 4, number of render-block pixel inputs
- `PIX_LAT`, 1, clock cycles from address to render-block pixel
- `FG_COLOR`, 12'h555, foreground RGB (4:4:4)
- `BG_COLOR`, 12'hFFF, background RGB

- `clk` in 1 — 25.175 MHz pixel-rate clock
- `reset_n` in 1 — asynchronous, active-low reset
- `en` in 1 — pixel enable; all state advances only when high (tie high at 25.175 MHz)
- `layer_pixel` in N_LAYERS — registered pixel bits from render blocks
- `invert` in 1 — night-mode request
- `haddress` out 10 — current column, 0..799
- `vaddress` out 10 — current line, 0..524
- `frame_tick` out 1 — one-`en`-cycle pulse at start of vertical blanking
- `hsync`, `vsync` out 1 each — active-low sync
- `red`, `green`, `blue` out 4 each — pixel colour

## Operation
- `haddress` increments each `en` cycle; wraps 799→0. On wrap, `vaddress` increments; wraps 524→0 when `haddress` also wraps.
- Addresses run through blanking; consumers gate on `<640` / `<480`.
- Raw video_on = `haddress<640 && vaddress<480`; raw hsync low for `haddress` 656..751; raw vsync low for `vaddress` 490..491.
- Raw video_on/hsync/vsync pass through a delay of PIX_LAT stages so they align with `layer_pixel`.
- Output stage (registered): if aligned video_on is 0 → RGB 0. Else colour = FG_COLOR if any `layer_pixel` bit set, else BG_COLOR; swapped when night mode active.
- Night mode register loads `invert` only on the `en` cycle where `frame_tick` asserts; mid-frame `invert` changes have no visible effect until next tick.
- `frame_tick` high for the single `en` cycle where `haddress==0 && vaddress==480`.
- `en` low: counters, delay line, output registers and `frame_tick` hold; `frame_tick` never lasts more than one `en` cycle.

## Timing
- Reset (async assert): `haddress`=0, `vaddress`=0, `frame_tick`=0, `hsync`=`vsync`=1, RGB=0, night mode=0, delay line cleared to blank/deasserted-sync.
- Reset release mid-frame restarts at (0,0); first hsync falls 656 `en` cycles after first active `en` edge, plus PIX_LAT+1.
- Latency: address presented at cycle n → `hsync`/`vsync`/RGB for that address valid after edge n+PIX_LAT+1 (default n+2).
- `frame_tick` is registered from the counters (not delayed); asserts the cycle `vaddress` reads 480, `haddress` 0.
- Simultaneous h and v wrap at (799,524): next address (0,0) in one step.

## Structure
- Package `vga_pkg`: timing constants (H/V totals, sync start/end), default colours, RGB 4:4:4 typedef.
- Sub-module `sync_delay`: parameterized-depth shift register (width 3: video_on, hsync, vsync) with async active-low clear and enable; reused by render blocks needing alignment.
- Counters, tick, night-mode register and colour mux stay in `vga_sync`.

## Test plan
- Reset, `en`=1, run 800×525 cycles → `haddress` sequence 0..799 repeats, `vaddress` 0..524, exactly 525 hsync pulses of 96 cycles and one vsync pulse of 1600 cycles per frame.
- `layer_pixel`=4'b0001 only when render input models address (10,10) with PIX_LAT=1 → RGB=12'h555 exactly at output for that position, 12'hFFF elsewhere in active area, 0 in blanking.
- `invert` pulsed high at line 100, held → colours unchanged until `frame_tick`, then FG/BG swapped for whole next frame.
- `en` toggled 1/0 alternately → counts advance every second clock, sync widths double in clocks, `frame_tick` one `en`-cycle wide.
- Assert `reset_n`=0 at (300,200) for 3 cycles → outputs immediately at reset values; after release scan resumes at (0,0).
- Check `frame_tick` asserted exactly once per 420 000 `en` cycles, at (0,480).
